// File: rtl/multicycle_control_fsm.sv
// Main controller for a multi-cycle MIPS-subset datapath.
// Sequences fetch/decode/execute, stalls on memory, counts retires, traps on illegal ops.
module multicycle_control_fsm #(
   parameter int STAT_W = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [5:0]        Opcode,
   input  logic [5:0]        Funct,
   input  logic              Zero,
   input  logic              Mem_ready,
   output logic              PCWrite,
   output logic              IorD,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              RegDst,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ALUOp,
   output logic [1:0]        PCSource,
   output logic [3:0]        State,
   output logic              Illegal,
   output logic [STAT_W-1:0] Inst_count
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      TRAP   = 4'd15
   } state_t;

   state_t state;
   state_t next;
   logic   funct_ok;
   logic   retire;
   logic   pc_wr;
   logic   mem_rd;
   logic   mem_wr;
   logic   ir_wr;
   logic   reg_wr;

   assign State = state;

   always_comb begin
      funct_ok = (Funct == 6'h20) || (Funct == 6'h22) ||
                 (Funct == 6'h24) || (Funct == 6'h25) ||
                 (Funct == 6'h2A);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= FETCH;
         Inst_count <= '0;
         Illegal    <= 1'b0;
      end else begin
         state <= next;
         if (retire)
            Inst_count <= Inst_count + STAT_W'(1);
         if (next == TRAP)
            Illegal <= 1'b1;
      end
   end

   always_comb begin
      next     = state;
      pc_wr    = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      IorD     = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSource = 2'b00;
      unique case (state)
         FETCH: begin
            mem_rd  = 1'b1;
            ALUSrcB = 2'b01;
            ir_wr   = Mem_ready;
            pc_wr   = Mem_ready;
            if (Mem_ready)
               next = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (Opcode)
               6'h23, 6'h2B: next = MEMADR;
               6'h00:        next = funct_ok ? EXEC : TRAP;
               6'h04:        next = BRANCH;
               6'h02:        next = JUMP;
               6'h08:        next = ADDIEX;
               default:      next = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            next    = (Opcode == 6'h2B) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_rd = 1'b1;
            IorD   = 1'b1;
            if (Mem_ready)
               next = MEMWB;
         end
         MEMWB: begin
            reg_wr   = 1'b1;
            MemtoReg = 1'b1;
            next     = FETCH;
         end
         MEMWR: begin
            mem_wr = 1'b1;
            IorD   = 1'b1;
            if (Mem_ready)
               next = FETCH;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            next    = ALUWB;
         end
         ALUWB: begin
            reg_wr = 1'b1;
            RegDst = 1'b1;
            next   = FETCH;
         end
         BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSource = 2'b01;
            pc_wr    = Zero;
            next     = FETCH;
         end
         JUMP: begin
            PCSource = 2'b10;
            pc_wr    = 1'b1;
            next     = FETCH;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            next    = ADDIWB;
         end
         ADDIWB: begin
            reg_wr = 1'b1;
            next   = FETCH;
         end
         TRAP: next = TRAP;
         default: next = FETCH;
      endcase
   end

   // An instruction retires only when it completes back into FETCH.
   always_comb begin
      retire = !Reset && (next == FETCH) &&
               ((state == MEMWB) || (state == MEMWR) ||
                (state == ALUWB) || (state == BRANCH) ||
                (state == JUMP)  || (state == ADDIWB));
   end

   assign PCWrite  = pc_wr  & ~Reset;
   assign MemRead  = mem_rd & ~Reset;
   assign MemWrite = mem_wr & ~Reset;
   assign IRWrite  = ir_wr  & ~Reset;
   assign RegWrite = reg_wr & ~Reset;

endmodule
